// File: rtl/ann_stream_loader_if.sv
// rtl/ann_stream_loader_if.sv - byte stream valid/ready bundle feeding the ANN loader
interface ann_stream_loader_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/ann_stream_loader.sv
// rtl/ann_stream_loader.sv - byte stream to classifier memory writer, start/done sequencer
// Optional done-wait watchdog: ANN_LOADER_TIMEOUT_EN
module ann_stream_loader #(
  parameter int ADDR_W         = 14,
  parameter int IMG_BYTES      = 784,
  parameter int MEM_DEPTH      = 16384,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  ann_stream_loader_if.slave s,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              start,
  input  logic              done_in,
  input  logic [3:0]        class_in,
  output logic              result_valid,
  output logic [3:0]        result_class,
  output logic              busy,
  output logic              err_short,
  output logic              err_overflow,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(MEM_DEPTH + 1);
  localparam logic [CNT_W-1:0] MEM_T = CNT_W'(MEM_DEPTH);
  localparam logic [CNT_W:0]   IMG_T = (CNT_W + 1)'(IMG_BYTES);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, START, WAIT_DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  count_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              start_q;
  logic              result_valid_q;
  logic [3:0]        result_class_q;
  logic              err_short_q;
  logic              err_overflow_q;
  logic              xfer;
  logic [CNT_W:0]    total_d;

`ifdef ANN_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q;
  logic             err_timeout_q;
  assign err_timeout = err_timeout_q;
`else
  // Never true; the parameter stays referenced with the watchdog compiled out
  assign err_timeout = (TIMEOUT_CYCLES < 0);
`endif

  assign s.s_ready = rst_n && (state_q == IDLE || state_q == LOAD || state_q == DRAIN);
  assign xfer      = s.s_valid && s.s_ready;
  // Stream length including the byte currently being accepted
  assign total_d   = {1'b0, count_q} + (CNT_W + 1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      count_q        <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      start_q        <= 1'b0;
      result_valid_q <= 1'b0;
      result_class_q <= '0;
      err_short_q    <= 1'b0;
      err_overflow_q <= 1'b0;
`ifdef ANN_LOADER_TIMEOUT_EN
      tmo_q          <= '0;
      err_timeout_q  <= 1'b0;
`endif
    end else begin
      wr_en_q        <= 1'b0;
      start_q        <= 1'b0;
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE, LOAD: begin
          if (xfer) begin
            if (state_q == IDLE) begin
              err_short_q    <= 1'b0;
              err_overflow_q <= 1'b0;
`ifdef ANN_LOADER_TIMEOUT_EN
              err_timeout_q  <= 1'b0;
`endif
            end
            if (count_q != MEM_T) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= ADDR_W'(count_q);
              wr_data_q <= s.s_data;
              count_q   <= count_q + CNT_W'(1);
              if (!s.s_last) begin
                state_q <= LOAD;
              end else if (total_d < IMG_T) begin
                err_short_q <= 1'b1;
                count_q     <= '0;
                state_q     <= IDLE;
              end else begin
                state_q <= START;
              end
            end else begin
              // Memory full: this byte and the rest of the stream are dropped
              err_overflow_q <= 1'b1;
              if (s.s_last) begin
                count_q <= '0;
                state_q <= IDLE;
              end else begin
                state_q <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (xfer && s.s_last) begin
            count_q <= '0;
            state_q <= IDLE;
          end
        end
        START: begin
          start_q <= 1'b1;
          count_q <= '0;
`ifdef ANN_LOADER_TIMEOUT_EN
          tmo_q   <= '0;
`endif
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // start_q is high during the start cycle; done_in there is ignored
          if (!start_q) begin
            if (done_in) begin
              result_class_q <= class_in;
              result_valid_q <= 1'b1;
              state_q        <= IDLE;
            end
`ifdef ANN_LOADER_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
              err_timeout_q <= 1'b1;
              state_q       <= IDLE;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign start        = start_q;
  assign result_valid = result_valid_q;
  assign result_class = result_class_q;
  assign busy         = (state_q != IDLE);
  assign err_short    = err_short_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_ann_stream_loader.sv
// tb/tb_ann_stream_loader.sv - scoreboard bench for ann_stream_loader
module tb_ann_stream_loader;
  localparam int ADDR_W    = 14;
  localparam int IMG_BYTES = 784;
  localparam int MEM_DEPTH = 4096;
  localparam int TMO       = 50;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en, start, done_in, result_valid, busy;
  logic              err_short, err_overflow, err_timeout;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [3:0]        class_in, result_class;

  ann_stream_loader_if sif ();

  ann_stream_loader #(
    .ADDR_W(ADDR_W), .IMG_BYTES(IMG_BYTES), .MEM_DEPTH(MEM_DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s(sif.slave),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .done_in(done_in), .class_in(class_in),
    .result_valid(result_valid), .result_class(result_class), .busy(busy),
    .err_short(err_short), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int                    n_vec = 0;
  int                    n_err = 0;
  int                    n_starts = 0;
  int                    exp_start = 0;
  logic [ADDR_W+7:0]     exp_q[$];
  logic [3:0]            exp_res[$];
  logic                  prev_wr_en = 1'b0;
  logic [2:0]            first_errs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + (i >> 8));
  endfunction

  // Monitor: pops expectations whenever the DUT presents a write, start or result
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr", 1, 0);
        end else begin
          logic [ADDR_W+7:0] e;
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e[ADDR_W+7:8]);
          check("wr_data", wr_data, e[7:0]);
        end
      end
      if (start) begin
        n_starts++;
        check("start_expected", exp_start > 0, 1);
        if (exp_start > 0) exp_start--;
        check("start_overlaps_wr", wr_en, 0);
        check("start_after_last_wr", prev_wr_en, 1);
        check("writes_done_at_start", exp_q.size(), 0);
      end
      if (result_valid) begin
        if (exp_res.size() == 0) check("unexpected_result", 1, 0);
        else check("result_class", result_class, exp_res.pop_front());
      end
    end
    prev_wr_en = wr_en;
  end

  task automatic send_stream(input int n, input bit bursty, input bit with_last);
    int guard;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 1) first_errs = {err_short, err_overflow, err_timeout};
      if (bursty) begin
        while ($urandom_range(0, 2) == 0) begin
          sif.s_valid = 1'b0;
          @(negedge clk);
        end
      end
      sif.s_valid = 1'b1;
      sif.s_data  = pat(i);
      sif.s_last  = with_last && (i == n - 1);
      guard = 0;
      while (!sif.s_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (!sif.s_ready) begin
        check("s_ready_wait_expired", 0, 1);
        break;
      end
      if (i < MEM_DEPTH) exp_q.push_back({ADDR_W'(i), pat(i)});
      if (with_last && i == n - 1 && n >= IMG_BYTES && n <= MEM_DEPTH) exp_start++;
      @(posedge clk);
    end
    @(negedge clk);
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  task automatic wait_start();
    bit ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = start;
    end
    check("start_seen", ok, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int starts_before;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_last  = 1'b0;
    done_in     = 1'b0;
    class_in    = '0;

    // Reset state
    #12;
    check("rst_s_ready", sif.s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_start", start, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_class", result_class, 0);
    check("rst_errs", {err_short, err_overflow, err_timeout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("idle_s_ready", sif.s_ready, 1);

    // Full load, result captured on fifth cycle after start
    send_stream(IMG_BYTES + 2000, 1'b0, 1'b1);
    wait_start();
    check("start_cycle_s_ready", sif.s_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("wait_s_ready", sif.s_ready, 0);
      check("wait_busy", busy, 1);
    end
    done_in = 1'b1; class_in = 4'd6; exp_res.push_back(4'd6);
    @(negedge clk);
    done_in = 1'b0;
    check("res_valid_pulse", result_valid, 1);
    @(negedge clk);
    check("res_valid_one_cycle", result_valid, 0);
    check("res_class_held", result_class, 6);
    check("res_busy", busy, 0);
    check("res_s_ready", sif.s_ready, 1);
    check("full_errs", {err_short, err_overflow, err_timeout}, 0);

    // Bursty 800 bytes; done_in during start cycle must be ignored
    send_stream(800, 1'b1, 1'b1);
    wait_start();
    done_in = 1'b1; class_in = 4'd9;
    @(negedge clk);
    done_in = 1'b0;
    check("done_in_start_ignored", result_valid, 0);
    check("done_in_start_busy", busy, 1);
    repeat (3) begin
      @(negedge clk);
      check("burst_wait_s_ready", sif.s_ready, 0);
    end
    done_in = 1'b1; class_in = 4'd3; exp_res.push_back(4'd3);
    @(negedge clk);
    done_in = 1'b0;
    @(negedge clk);
    check("burst_res_class", result_class, 3);

    // Short stream
    starts_before = n_starts;
    send_stream(100, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("short_err", err_short, 1);
    check("short_busy", busy, 0);
    check("short_no_start", n_starts, starts_before);

    // Overflow: first byte clears err_short, writes stop at MEM_DEPTH-1
    send_stream(MEM_DEPTH + 6, 1'b0, 1'b1);
    check("next_stream_clears_errs", first_errs, 0);
    repeat (5) @(negedge clk);
    check("ovf_err", err_overflow, 1);
    check("ovf_short_clear", err_short, 0);
    check("ovf_busy", busy, 0);
    check("ovf_no_start", n_starts, starts_before);
    check("ovf_writes_drained", exp_q.size(), 0);

    // Reset mid-load
    send_stream(300, 1'b0, 1'b0);
    check("midload_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_start", start, 0);
    check("midrst_busy", busy, 0);
    check("midrst_errs", {err_short, err_overflow, err_timeout}, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_stream(IMG_BYTES, 1'b0, 1'b1);
    wait_start();
`ifdef ANN_LOADER_TIMEOUT_EN
    repeat (TMO) @(negedge clk);
    check("tmo_busy_terminal", busy, 1);
    @(negedge clk);
    check("tmo_busy_after", busy, 0);
    check("tmo_err", err_timeout, 1);
    check("tmo_class_kept", result_class, 3);
    send_stream(IMG_BYTES, 1'b0, 1'b1);
    wait_start();
    repeat (TMO) @(negedge clk);
    done_in = 1'b1; class_in = 4'd11; exp_res.push_back(4'd11);
    @(negedge clk);
    done_in = 1'b0;
    check("tmo_edge_success", result_class, 11);
    check("tmo_edge_no_err", err_timeout, 0);
    check("tmo_edge_busy", busy, 0);
`else
    repeat (TMO + 10) @(negedge clk);
    check("notmo_busy", busy, 1);
    check("notmo_err", err_timeout, 0);
    done_in = 1'b1; class_in = 4'd5; exp_res.push_back(4'd5);
    @(negedge clk);
    done_in = 1'b0;
    check("notmo_res_class", result_class, 5);
`endif

    repeat (5) @(negedge clk);
    check("end_writes_pending", exp_q.size(), 0);
    check("end_starts_pending", exp_start, 0);
    check("end_results_pending", exp_res.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
